// File: rtl/fifo_stream_pkg.sv
// Shared constants for the fifo-to-stream adapter and its skid buffer.
package fifo_stream_pkg;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;
  localparam int LAT       = 1;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; head data reads as zero while empty.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_i) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_i) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_i, rd_i})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; an empty buffer masks stale contents from head_o.
  always_ff @(posedge clk_i) begin
    if (wr_i) mem[wr_ptr] <= wr_data_i;
  end

  assign head_o  = (count != '0) ? mem[rd_ptr] : '0;
  assign count_o = count;
endmodule

// File: rtl/fifo_to_stream.sv
// Converts a 1-cycle-latency fifo read port into a valid/ready stream.
module fifo_to_stream
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rd_data_i,
  output logic             fifo_rd_req_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o
);
  logic [LAT-1:0] inflight_p1;
  logic           pop;
  logic [CNT_W:0] occupancy;

  assign pop = valid_o & ready_i;

  // Reserve a slot for the word in flight so the buffer can never overflow.
  assign occupancy = {1'b0, count_o}
                   + {{CNT_W{1'b0}}, inflight_p1[LAT-1]}
                   - {{CNT_W{1'b0}}, pop};

  assign fifo_rd_req_o = !rst_i && !fifo_empty_i
                         && (occupancy < (CNT_W+1)'(BUF_DEPTH));

  // Stage p1: request issued last cycle, data arrives now.
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_p1 <= '0;
    else       inflight_p1 <= LAT'(fifo_rd_req_o);
  end

  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (inflight_p1[LAT-1]),
    .wr_data_i(fifo_rd_data_i),
    .rd_i     (pop),
    .head_o   (data_o),
    .count_o  (count_o)
  );

  assign valid_o = (count_o != '0);
endmodule

// File: tb/tb_fifo_to_stream.sv
// Bench for fifo_to_stream: queue-based upstream fifo and occupancy model.
module tb_fifo_to_stream;
  typedef logic [3:0] word_t;

  logic  clk_tb = 1'b0;
  logic  rst, fifo_empty, fifo_rd_req, valid, ready;
  word_t fifo_rd_data, data;
  logic [1:0] count;

  always #5 clk_tb = ~clk_tb;

  fifo_to_stream #(.WIDTH(4)) dut (
    .clk_i         (clk_tb),
    .rst_i         (rst),
    .fifo_empty_i  (fifo_empty),
    .fifo_rd_data_i(fifo_rd_data),
    .fifo_rd_req_o (fifo_rd_req),
    .data_o        (data),
    .valid_o       (valid),
    .ready_i       (ready),
    .count_o       (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: fifo contents, words taken from the fifo not yet popped, held count.
  word_t fifo_q[$];
  word_t taken[$];
  int    m_cnt = 0;
  bit    m_inf = 1'b0;

  logic       obs_valid, obs_req, exp_valid, exp_req;
  logic [1:0] obs_cnt, exp_cnt;
  word_t      obs_data, exp_data;

  task automatic tick();
    bit pop;
    int occ;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk_tb);
    obs_valid = valid; obs_req = fifo_rd_req; obs_cnt = count; obs_data = data;
    exp_valid = (m_cnt != 0);
    exp_cnt   = 2'(m_cnt);
    exp_data  = exp_valid ? taken[0] : '0;
    pop       = exp_valid && ready;
    occ       = m_cnt + int'(m_inf) - int'(pop);
    exp_req   = !rst && !fifo_empty && (occ < 2);
    @(posedge clk_tb);
    if (rst) begin
      m_cnt = 0; m_inf = 1'b0; taken.delete();
    end else begin
      if (pop) begin void'(taken.pop_front()); m_cnt--; end
      if (m_inf) m_cnt++;
      if (exp_req) taken.push_back(fifo_q.pop_front());
      m_inf = exp_req;
    end
    #1;
    fifo_rd_data = exp_req ? taken[$] : word_t'($urandom);
  endtask

  task automatic drain();
    ready = 1'b1;
    repeat (12) tick();
  endtask

  function automatic logic [31:0] pack(input word_t q[$]);
    logic [31:0] acc = '0;
    foreach (q[k]) acc = {acc[27:0], q[k]};
    return acc;
  endfunction

  task automatic test_reset();
    word_t got[$];
    rst = 1'b1; ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) fifo_q.push_back(4'hA);
      tick();
      n_cmp += 4;
      if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", obs_valid); end
      if (obs_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", obs_cnt); end
      if (obs_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", obs_req); end
      if (obs_data !== 4'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", obs_data); end
    end
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp += 3;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL resume_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_cnt !== exp_cnt) begin n_bad++; $display("FAIL resume_count cyc=%0d got=%0d exp=%0d", i, obs_cnt, exp_cnt); end
      if (obs_req !== exp_req) begin n_bad++; $display("FAIL resume_req cyc=%0d got=%b exp=%b", i, obs_req, exp_req); end
      if (obs_valid) got.push_back(obs_data);
    end
    n_cmp++;
    if (got.size() != 1 || pack(got) !== 32'hA) begin
      n_bad++; $display("FAIL resume_words got=%h n=%0d exp=a n=1", pack(got), got.size());
    end
  endtask

  task automatic test_basic();
    word_t got[$];
    int t_req = -1, t_val = -1;
    ready = 1'b1;
    fifo_q.push_back(4'd1); fifo_q.push_back(4'd2); fifo_q.push_back(4'd3);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp += 3;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_cnt !== exp_cnt) begin n_bad++; $display("FAIL basic_count cyc=%0d got=%0d exp=%0d", i, obs_cnt, exp_cnt); end
      if (obs_req !== exp_req) begin n_bad++; $display("FAIL basic_req cyc=%0d got=%b exp=%b", i, obs_req, exp_req); end
      if (exp_valid) begin
        n_cmp++;
        if (obs_data !== exp_data) begin n_bad++; $display("FAIL basic_data cyc=%0d got=%h exp=%h", i, obs_data, exp_data); end
      end
      if (obs_req && t_req < 0) t_req = i;
      if (obs_valid && t_val < 0) t_val = i;
      if (obs_valid) got.push_back(obs_data);
    end
    n_cmp += 3;
    if (t_val - t_req != 2) begin n_bad++; $display("FAIL basic_latency got=%0d exp=2", t_val - t_req); end
    if (pack(got) !== 32'h123 || got.size() != 3) begin n_bad++; $display("FAIL basic_words got=%h exp=123", pack(got)); end
    if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle got=%b exp=0", obs_valid); end
  endtask

  task automatic test_backpressure();
    word_t got[$];
    int nreq = 0, first = -1, last = -1;
    ready = 1'b0;
    for (int w = 1; w <= 4; w++) fifo_q.push_back(word_t'(w));
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp += 3;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_req !== exp_req) begin n_bad++; $display("FAIL bp_req cyc=%0d got=%b exp=%b", i, obs_req, exp_req); end
      if (obs_valid !== 1'b0 && obs_data !== 4'd1) begin n_bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=1", i, obs_data); end
      if (obs_req) nreq++;
    end
    n_cmp += 3;
    if (nreq != 2) begin n_bad++; $display("FAIL bp_nreq got=%0d exp=2", nreq); end
    if (obs_cnt !== 2'd2) begin n_bad++; $display("FAIL bp_count got=%0d exp=2", obs_cnt); end
    if (obs_data !== 4'd1) begin n_bad++; $display("FAIL bp_head got=%h exp=1", obs_data); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp += 2;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL bp2_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp2_count cyc=%0d got=%0d exp=%0d", i, obs_cnt, exp_cnt); end
      if (obs_valid) begin
        got.push_back(obs_data);
        if (first < 0) first = i;
        last = i;
      end
    end
    n_cmp += 2;
    if (pack(got) !== 32'h1234 || got.size() != 4) begin n_bad++; $display("FAIL bp_words got=%h exp=1234", pack(got)); end
    if (last - first != 3) begin n_bad++; $display("FAIL bp_gaps span=%0d exp=3", last - first); end
  endtask

  task automatic test_empty();
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      ready = 1'($urandom);
      tick();
      if (obs_req !== 1'b0 || obs_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL empty_active got=%0d cycles exp=0", seen); end
  endtask

  task automatic test_alternate();
    word_t got[$];
    int next_w = 5;
    for (int i = 0; i < 24; i++) begin
      if (next_w <= 9 && fifo_q.size() < 4) begin fifo_q.push_back(word_t'(next_w)); next_w++; end
      ready = (i % 2 == 0);
      tick();
      n_cmp += 3;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL alt_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_cnt !== exp_cnt) begin n_bad++; $display("FAIL alt_count cyc=%0d got=%0d exp=%0d", i, obs_cnt, exp_cnt); end
      if (obs_req !== exp_req) begin n_bad++; $display("FAIL alt_req cyc=%0d got=%b exp=%b", i, obs_req, exp_req); end
      if (obs_valid && ready) got.push_back(obs_data);
    end
    n_cmp++;
    if (pack(got) !== 32'h56789 || got.size() != 5) begin n_bad++; $display("FAIL alt_words got=%h exp=56789", pack(got)); end
  endtask

  task automatic test_inflight_reset();
    word_t got[$];
    ready = 1'b0;
    fifo_q.push_back(4'hF);
    tick();
    n_cmp++;
    if (obs_req !== 1'b1) begin n_bad++; $display("FAIL ifr_req got=%b exp=1", obs_req); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs_req !== 1'b0) begin n_bad++; $display("FAIL ifr_req_rst got=%b exp=0", obs_req); end
    rst = 1'b0;
    fifo_q.push_back(4'h3);
    tick();
    n_cmp += 2;
    if (obs_cnt !== 2'd0) begin n_bad++; $display("FAIL ifr_count got=%0d exp=0", obs_cnt); end
    if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL ifr_valid got=%b exp=0", obs_valid); end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_valid) got.push_back(obs_data);
    end
    n_cmp++;
    if (pack(got) !== 32'h3 || got.size() != 1) begin n_bad++; $display("FAIL ifr_words got=%h n=%0d exp=3 n=1", pack(got), got.size()); end
  endtask

  task automatic test_refill();
    int first = -1, bubbles = 0;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      while (fifo_q.size() < 4) fifo_q.push_back(4'hF);
      tick();
      n_cmp += 2;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL refill_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_valid && obs_data !== 4'hF) begin n_bad++; $display("FAIL refill_data cyc=%0d got=%h exp=f", i, obs_data); end
      if (obs_valid && first < 0) first = i;
      if (first >= 0 && !obs_valid) bubbles++;
    end
    n_cmp++;
    if (bubbles != 0 || first < 0) begin n_bad++; $display("FAIL refill_bubble got=%0d first=%0d exp=0", bubbles, first); end
  endtask

  task automatic test_random();
    word_t pushed[$];
    word_t got[$];
    for (int i = 0; i < 420; i++) begin
      if (i < 400 && fifo_q.size() < 4 && $urandom_range(0, 2) != 0) begin
        word_t w = word_t'($urandom);
        fifo_q.push_back(w); pushed.push_back(w);
      end
      ready = (i >= 400) || ($urandom_range(0, 3) != 0);
      tick();
      n_cmp += 3;
      if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
      if (obs_cnt !== exp_cnt) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, obs_cnt, exp_cnt); end
      if (obs_req !== exp_req) begin n_bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, obs_req, exp_req); end
      if (obs_valid && ready) got.push_back(obs_data);
    end
    n_cmp++;
    if (got.size() != pushed.size()) begin
      n_bad++; $display("FAIL rnd_len got=%0d exp=%0d", got.size(), pushed.size());
    end else begin
      foreach (got[k]) begin
        n_cmp++;
        if (got[k] !== pushed[k]) begin n_bad++; $display("FAIL rnd_word idx=%0d got=%h exp=%h", k, got[k], pushed[k]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
    test_reset();        drain();
    test_basic();        drain();
    test_backpressure(); drain();
    test_empty();        drain();
    test_alternate();    drain();
    test_inflight_reset(); drain();
    test_refill();       drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exceeded 200000 time units");
    $fatal(1);
  end
endmodule
